// File: rtl/issue_scoreboard.sv
// Decode-and-issue stage: decodes RV32I words into 3-bit register indices and
// enables, stalls on busy registers, and issues through a one-entry output register.
module issue_scoreboard #(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [2:0]         out_rs1,
  output logic [2:0]         out_rs2,
  output logic [2:0]         out_rd,
  output logic               out_rs1_en,
  output logic               out_rs2_en,
  output logic               out_we,
  output logic               out_illegal,
  input  logic               wb_en,
  input  logic [2:0]         wb_rd,
  input  logic               flush,
  output logic [7:0]         busy_mask,
  output logic               wb_err,
  output logic [STALL_W-1:0] stall_cycles
);

  // Handshake: a word transfers on any edge where valid && ready are both high;
  // valid never depends on ready, and a held entry stays stable until it transfers.

  logic [2:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rs1_en, dec_rs2_en, dec_we, dec_illegal;
  logic       hazard, accept;
  logic [7:0] busy_flush, busy_nxt;
  logic       wb_bad;

  assign dec_rd  = in_instr[9:7];
  assign dec_rs1 = in_instr[17:15];
  assign dec_rs2 = in_instr[22:20];

  always_comb begin
    dec_rs1_en  = 1'b0;
    dec_rs2_en  = 1'b0;
    dec_we      = 1'b0;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0110011: begin
        dec_rs1_en = 1'b1;
        dec_rs2_en = 1'b1;
        dec_we     = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_rs1_en = 1'b1;
        dec_we     = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        dec_rs1_en = 1'b1;
        dec_rs2_en = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        dec_we = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // busy_mask[0] is held at zero, so index 0 can never hazard.
  assign hazard = (dec_rs1_en & busy_mask[dec_rs1]) |
                  (dec_rs2_en & busy_mask[dec_rs2]) |
                  (dec_we     & busy_mask[dec_rd]);

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush clear first, then writeback clear, then the new writer's set wins.
  always_comb begin
    busy_flush = busy_mask;
    if (flush && out_valid && out_we && (out_rd != 3'd0)) begin
      busy_flush[out_rd] = 1'b0;
    end
    busy_nxt = busy_flush;
    wb_bad   = 1'b0;
    if (wb_en && (wb_rd != 3'd0)) begin
      wb_bad          = !busy_flush[wb_rd];
      busy_nxt[wb_rd] = 1'b0;
    end
    if (accept && dec_we && (dec_rd != 3'd0)) begin
      busy_nxt[dec_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rs1_en  <= 1'b0;
      out_rs2_en  <= 1'b0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_instr   <= in_instr;
      out_rs1     <= dec_rs1;
      out_rs2     <= dec_rs2;
      out_rd      <= dec_rd;
      out_rs1_en  <= dec_rs1_en;
      out_rs2_en  <= dec_rs2_en;
      out_we      <= dec_we;
      out_illegal <= dec_illegal;
    end else if (flush || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask    <= '0;
      wb_err       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      busy_mask <= busy_nxt;
      if (wb_bad) begin
        wb_err <= 1'b1;
      end
      if (in_valid && hazard && !flush && (stall_cycles != {STALL_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule
